bypass_network: RTL
===================

// Module: bypass_network
// PURPOSE
//   Parametrised operand bypass/interlock unit for the decode->execute boundary.
//   Compares NUM_SRC decode-stage source register indices against NUM_STG in-flight
//   producer stages and one long-latency writeback channel (divider / uncached load).
//   Returns the youngest matching result, or raises a stall request.
//   Keeps a per-register busy scoreboard for long-latency ops still in flight.
//   Forward flags/data are registered into the execute stage under the pipeline stall vector.
// PARAMETERS
//   NUM_SRC    3    source operands checked per instruction
//   NUM_STG    4    producer stages; index 0 = youngest (EX), highest priority
//   DEST_WD    5    register index width; register 0 is hard-wired zero
//   RESULT_WD  32   data width
//   STALL_WD   6    width of pipeline stall vector
//   STALL_ID   2    stall bit of this boundary; STALL_ID+1 is the next stage's bit
// PORTS
//   clk            in   1                   clock
//   reset          in   1                   synchronous, active-high
//   flush          in   1                   pipeline flush
//   stall          in   STALL_WD            pipeline stall vector
//   src_addr       in   NUM_SRC*DEST_WD     decode source indices; slot i at [i*DEST_WD +: DEST_WD]
//   stg_we         in   NUM_STG             stage k writes a register
//   stg_dest       in   NUM_STG*DEST_WD     stage k destination index
//   stg_result     in   NUM_STG*RESULT_WD   stage k result
//   stg_pend       in   NUM_STG             stage k result not yet valid (load, mul in flight)
//   lng_issue      in   1                   long-latency op leaves decode this cycle
//   lng_issue_dest in   DEST_WD             its destination index
//   lng_done       in   1                   long-latency writeback this cycle
//   lng_dest       in   DEST_WD             writeback destination index
//   lng_result     in   RESULT_WD           writeback data
//   src_fwd_vld    out  NUM_SRC             registered: slot i uses forwarded data
//   src_fwd_data   out  NUM_SRC*RESULT_WD   registered forwarded data
//   stallreq_fwd   out  1                   combinational interlock request
//   lng_busy_any   out  1                   any scoreboard bit set
// BEHAVIOUR
//   Match: hit[i][k] = stg_we[k] & (src_i == stg_dest[k]) & (src_i != 0).
//   Long-latency match: lhit[i] = lng_done & (src_i == lng_dest) & (src_i != 0).
//   Priority: lowest k wins; lhit is below all stages. No hit -> vld 0, data 0.
//   Stall: stallreq_fwd = OR over i of either:
//     - the winning stage k has stg_pend[k] = 1 (an older, valid match does NOT mask it);
//     - busy[src_i] & !lhit[i] & no stage hit.
//   Scoreboard busy[1..2^DEST_WD-1]: all 0 on reset.
//     - Set on lng_issue & !stall[STALL_ID] & lng_issue_dest != 0.
//     - Clear on lng_done.
//     - Set and clear of the same index in one cycle: set wins.
//     - Index 0 is never set. Flush does NOT clear busy (the op must still write back).
//   Output register update, first matching rule wins:
//     1. reset or flush: vld <= 0, data <= 0.
//     2. stall[STALL_ID] & !stall[STALL_ID+1]: vld <= 0, data <= 0 (bubble).
//     3. !stall[STALL_ID]: capture the combinational selection.
//     4. Otherwise: hold.
//   Latency: selection is combinational from the inputs; outputs are valid one cycle later in EX.
//   stallreq_fwd is combinational, independent of stall, and low during reset.
//   lng_busy_any = |busy, registered view (reflects the scoreboard after the edge).
// TESTING
//   1. src0=5, stg0 we dest5 result 0xAAAA, stg2 dest5 result 0xBBBB, no stall
//      -> next cycle vld[0]=1, data0=0xAAAA; stall=0.
//   2. src1=7 matches stg1 with pend=1, stg3 also matches with valid data
//      -> stallreq_fwd=1; with stall=6'b000111, next cycle vld=0, data=0.
//   3. Issue lng to r9, then src2=9 with no stage hit -> stall=1 for N cycles.
//      lng_done dest9 result 0x1234 -> stall=0, next cycle data2=0x1234; busy cleared.
//   4. src=0 matching stg0 dest0 we=1 -> vld=0, stall=0.
//      lng_issue_dest=0 -> busy stays 0.
//   5. lng_done r4 and lng_issue r4 in the same cycle -> busy[4]=1 afterwards.
//      Flush mid-operation -> busy[4] still 1, outputs 0.
//   6. Reset asserted with busy bits set and stall held
//      -> all outputs 0, lng_busy_any=0 the cycle after reset.

Source files
------------

// File: rtl/bypass_network.sv
// rtl/bypass_network.sv - operand bypass/interlock unit at the decode->execute boundary
// Youngest-match forwarding with long-latency busy scoreboard and registered EX outputs.
module bypass_network #(
    parameter int NUM_SRC   = 3,
    parameter int NUM_STG   = 4,
    parameter int DEST_WD   = 5,
    parameter int RESULT_WD = 32,
    parameter int STALL_WD  = 6,
    parameter int STALL_ID  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [STALL_WD-1:0]            stall,
    input  logic [NUM_SRC*DEST_WD-1:0]     src_addr,
    input  logic [NUM_STG-1:0]             stg_we,
    input  logic [NUM_STG*DEST_WD-1:0]     stg_dest,
    input  logic [NUM_STG*RESULT_WD-1:0]   stg_result,
    input  logic [NUM_STG-1:0]             stg_pend,
    input  logic                           lng_issue,
    input  logic [DEST_WD-1:0]             lng_issue_dest,
    input  logic                           lng_done,
    input  logic [DEST_WD-1:0]             lng_dest,
    input  logic [RESULT_WD-1:0]           lng_result,
    output logic [NUM_SRC-1:0]             src_fwd_vld,
    output logic [NUM_SRC*RESULT_WD-1:0]   src_fwd_data,
    output logic                           stallreq_fwd,
    output logic                           lng_busy_any
);

    localparam int NUM_REG = 1 << DEST_WD;

    logic [NUM_REG-1:0]           busy_q, busy_d;
    logic [NUM_SRC-1:0]           vld_q, vld_d;
    logic [NUM_SRC*RESULT_WD-1:0] data_q, data_d;

    logic [NUM_SRC-1:0]           sel_vld;
    logic [NUM_SRC*RESULT_WD-1:0] sel_data;
    logic [NUM_SRC-1:0]           slot_stall;

    logic                         stall_unused;
    assign stall_unused = ^stall;

    // Stages are scanned oldest-first so the youngest hit overwrites; the
    // pend flag of that winner decides the interlock regardless of older hits.
    always_comb begin
        logic [DEST_WD-1:0] src;
        logic               any_hit;
        logic               win_pend;
        logic               lhit;
        sel_vld    = '0;
        sel_data   = '0;
        slot_stall = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src      = src_addr[i*DEST_WD +: DEST_WD];
            any_hit  = 1'b0;
            win_pend = 1'b0;
            lhit     = lng_done && (lng_dest == src) && (src != '0);
            if (lhit) begin
                sel_vld[i]                       = 1'b1;
                sel_data[i*RESULT_WD +: RESULT_WD] = lng_result;
            end
            for (int k = NUM_STG - 1; k >= 0; k--) begin
                if (stg_we[k] && (stg_dest[k*DEST_WD +: DEST_WD] == src) && (src != '0)) begin
                    any_hit                            = 1'b1;
                    win_pend                           = stg_pend[k];
                    sel_vld[i]                         = 1'b1;
                    sel_data[i*RESULT_WD +: RESULT_WD] = stg_result[k*RESULT_WD +: RESULT_WD];
                end
            end
            slot_stall[i] = win_pend | (busy_q[src] & ~lhit & ~any_hit);
        end
    end

    assign stallreq_fwd = (|slot_stall) & ~reset;

    // Clear applied before set so a same-index retire/reissue stays busy.
    always_comb begin
        busy_d = busy_q;
        if (lng_done) begin
            busy_d[lng_dest] = 1'b0;
        end
        if (lng_issue && !stall[STALL_ID] && (lng_issue_dest != '0)) begin
            busy_d[lng_issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush || (stall[STALL_ID] && !stall[STALL_ID+1])) begin
            vld_d  = '0;
            data_d = '0;
        end else if (!stall[STALL_ID]) begin
            vld_d  = sel_vld;
            data_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign src_fwd_vld  = vld_q;
    assign src_fwd_data = data_q;
    assign lng_busy_any = |busy_q;

endmodule
